// File: rtl/dmem_if.sv
// Load/store bus between the core datapath and the data-memory responder.
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [15:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Single-outstanding data-memory responder with programmable wait states.
// Optional misalignment errors are enabled by defining DMEM_ALIGN_CHECK_EN.
//
// state | meaning
// IDLE  | ready for a request
// WAIT  | counting wait states down to the access edge
// RESP  | presenting the response until rsp_ready
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic   clk,
  input  logic   reset,
  dmem_if.slave  bus
);
  localparam int          AW    = $clog2(DEPTH_WORDS);
  localparam logic [16:0] LIMIT = 17'(4 * DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      r_state, w_next;
  logic [3:0]  r_cnt, w_cnt_next;
  logic        r_write, r_uns, r_err;
  logic [15:0] r_addr;
  logic [1:0]  r_size;
  logic [31:0] r_wdata, r_rdata;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic          w_accept, w_access, w_sel_in, w_err, w_misalign, w_mem_we;
  logic          w_write, w_uns;
  logic [15:0]   w_addr;
  logic [1:0]    w_size;
  logic [31:0]   w_wdata, w_word, w_shift, w_load, w_wd;
  logic [15:0]   w_half;
  logic [3:0]    w_be;
  logic [AW-1:0] w_idx;

  assign bus.req_ready = (r_state == IDLE) && reset;
  assign bus.rsp_valid = (r_state == RESP);
  assign bus.rsp_rdata = r_rdata;
  assign bus.rsp_err   = r_err;
  assign w_accept      = bus.req_valid && bus.req_ready;

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_access   = 1'b0;
    case (r_state)
      IDLE: if (w_accept) begin
        if (WAIT_CYCLES == 0) begin
          w_access = 1'b1;
          w_next   = RESP;
        end else begin
          w_next     = WAIT;
          w_cnt_next = 4'(WAIT_CYCLES - 1);
        end
      end
      WAIT: if (r_cnt == 4'd0) begin
        w_access = 1'b1;
        w_next   = RESP;
      end else begin
        w_cnt_next = r_cnt - 4'd1;
      end
      RESP: if (bus.rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // With zero wait states the access happens on the accept edge, so use the live request.
  assign w_sel_in = (r_state == IDLE);
  assign w_write  = w_sel_in ? bus.req_write    : r_write;
  assign w_addr   = w_sel_in ? bus.req_addr     : r_addr;
  assign w_size   = w_sel_in ? bus.req_size     : r_size;
  assign w_uns    = w_sel_in ? bus.req_unsigned : r_uns;
  assign w_wdata  = w_sel_in ? bus.req_wdata    : r_wdata;

`ifdef DMEM_ALIGN_CHECK_EN
  assign w_misalign = ((w_size == 2'b01) && w_addr[0]) ||
                      ((w_size == 2'b10) && (w_addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_idx    = w_addr[AW+1:2];
  assign w_word   = r_mem[w_idx];
  assign w_shift  = w_word >> {w_addr[1:0], 3'b000};
  assign w_half   = w_addr[1] ? w_word[31:16] : w_word[15:0];
  assign w_err    = ({1'b0, w_addr} >= LIMIT) || (w_size == 2'b11) || w_misalign;
  assign w_mem_we = w_access && w_write && !w_err && reset;

  always_comb begin
    w_load = w_word;
    w_be   = 4'b1111;
    w_wd   = w_wdata;
    case (w_size)
      2'b00: begin
        w_load = {{24{~w_uns & w_shift[7]}}, w_shift[7:0]};
        w_be   = 4'b0001 << w_addr[1:0];
        w_wd   = {4{w_wdata[7:0]}};
      end
      2'b01: begin
        w_load = {{16{~w_uns & w_half[15]}}, w_half};
        w_be   = w_addr[1] ? 4'b1100 : 4'b0011;
        w_wd   = {2{w_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wd[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_write <= 1'b0;
      r_addr  <= 16'd0;
      r_size  <= 2'd0;
      r_uns   <= 1'b0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_write <= bus.req_write;
        r_addr  <= bus.req_addr;
        r_size  <= bus.req_size;
        r_uns   <= bus.req_unsigned;
        r_wdata <= bus.req_wdata;
      end
      if (w_access) begin
        r_err   <= w_err;
        r_rdata <= (w_err || w_write) ? 32'd0 : w_load;
      end
    end
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: two responders, WAIT_CYCLES=2 and WAIT_CYCLES=0.
module tb_data_mem_responder;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  dmem_if bus0();
  dmem_if bus1();

  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) u_dut (
    .clk(clk), .reset(reset), .bus(bus0)
  );
  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(reset), .bus(bus1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic fail_timeout(input string name);
    n_checks++;
    $display("FAIL %s: timeout got no event expected event", name);
  endtask

  // Response monitors: pop and compare on each response handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus0.rsp_valid && bus0.rsp_ready) begin
        if (q0.size() == 0) chk("dut_w2 unexpected rsp", 32'd1, 32'd0);
        else begin
          e = q0.pop_front();
          chk("dut_w2 rsp_rdata", bus0.rsp_rdata, e.rdata);
          chk("dut_w2 rsp_err", {31'd0, bus0.rsp_err}, {31'd0, e.err});
        end
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus1.rsp_valid && bus1.rsp_ready) begin
        if (q1.size() == 0) chk("dut_w0 unexpected rsp", 32'd1, 32'd0);
        else begin
          e = q1.pop_front();
          chk("dut_w0 rsp_rdata", bus1.rsp_rdata, e.rdata);
          chk("dut_w0 rsp_err", {31'd0, bus1.rsp_err}, {31'd0, e.err});
        end
      end
    end
  end

  task automatic issue0(input bit wr, input logic [15:0] addr, input logic [1:0] size,
                        input bit uns, input logic [31:0] wd, input bit push,
                        input logic [31:0] er, input bit ee);
    int n = 0;
    bus0.req_valid = 1'b1; bus0.req_write = wr; bus0.req_addr = addr;
    bus0.req_size = size; bus0.req_unsigned = uns; bus0.req_wdata = wd;
    if (push) q0.push_back('{rdata: er, err: ee});
    do begin @(negedge clk); n++; end while (!bus0.req_ready && n < 60);
    if (!bus0.req_ready) fail_timeout("dut_w2 accept");
    @(posedge clk); #1;
    bus0.req_valid = 1'b0;
  endtask

  task automatic issue1(input bit wr, input logic [15:0] addr, input logic [31:0] wd,
                        input logic [31:0] er, input bit ee);
    int n = 0;
    bus1.req_valid = 1'b1; bus1.req_write = wr; bus1.req_addr = addr;
    bus1.req_size = 2'b10; bus1.req_unsigned = 1'b0; bus1.req_wdata = wd;
    q1.push_back('{rdata: er, err: ee});
    do begin @(negedge clk); n++; end while (!bus1.req_ready && n < 60);
    if (!bus1.req_ready) fail_timeout("dut_w0 accept");
    @(posedge clk); #1;
    bus1.req_valid = 1'b0;
  endtask

  // Counts negedges after acceptance until rsp_valid, then steps past the handshake edge.
  task automatic wait_rsp0(output int lat);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!bus0.rsp_valid && lat < 60);
    if (!bus0.rsp_valid) fail_timeout("dut_w2 rsp_valid");
    @(posedge clk); #1;
  endtask

  task automatic wait_rsp1(output int lat);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!bus1.rsp_valid && lat < 60);
    if (!bus1.rsp_valid) fail_timeout("dut_w0 rsp_valid");
    @(posedge clk); #1;
  endtask

  task automatic xact0(input bit wr, input logic [15:0] addr, input logic [1:0] size,
                       input bit uns, input logic [31:0] wd,
                       input logic [31:0] er, input bit ee);
    int lat;
    issue0(wr, addr, size, uns, wd, 1'b1, er, ee);
    wait_rsp0(lat);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 60) begin @(negedge clk); n++; end
    if (q0.size() != 0 || q1.size() != 0) fail_timeout(name);
    @(posedge clk); #1;
  endtask

  initial begin
    int lat;
    int acc_t[$];
    int n;
    bus0.req_valid = 1'b0; bus0.req_write = 1'b0; bus0.req_addr = 16'd0;
    bus0.req_size = 2'd0; bus0.req_unsigned = 1'b0; bus0.req_wdata = 32'd0;
    bus0.rsp_ready = 1'b1;
    bus1.req_valid = 1'b0; bus1.req_write = 1'b0; bus1.req_addr = 16'd0;
    bus1.req_size = 2'd0; bus1.req_unsigned = 1'b0; bus1.req_wdata = 32'd0;
    bus1.rsp_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset req_ready", {31'd0, bus0.req_ready}, 32'd0);
    chk("reset rsp_valid", {31'd0, bus0.rsp_valid}, 32'd0);
    chk("reset rsp_rdata", bus0.rsp_rdata, 32'd0);
    chk("reset rsp_err", {31'd0, bus0.rsp_err}, 32'd0);
    chk("reset w0 rsp_valid", {31'd0, bus1.rsp_valid}, 32'd0);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk("post-reset req_ready", {31'd0, bus0.req_ready}, 32'd1);
    chk("post-reset w0 req_ready", {31'd0, bus1.req_ready}, 32'd1);
    @(posedge clk); #1;

    // Store word, measure latency, read back.
    issue0(1'b1, 16'h0010, 2'b10, 1'b0, 32'hDEADBEEF, 1'b1, 32'd0, 1'b0);
    wait_rsp0(lat);
    chk("latency w2", lat, 32'd3);
    xact0(1'b0, 16'h0010, 2'b10, 1'b0, 32'd0, 32'hDEADBEEF, 1'b0);

    // Byte/halfword lanes: word becomes 0x80ADBEEF.
    xact0(1'b1, 16'h0013, 2'b00, 1'b0, 32'h00000080, 32'd0, 1'b0);
    xact0(1'b0, 16'h0013, 2'b00, 1'b0, 32'd0, 32'hFFFFFF80, 1'b0);
    xact0(1'b0, 16'h0013, 2'b00, 1'b1, 32'd0, 32'h00000080, 1'b0);
    xact0(1'b0, 16'h0012, 2'b01, 1'b0, 32'd0, 32'hFFFF80AD, 1'b0);
    xact0(1'b0, 16'h0010, 2'b01, 1'b1, 32'd0, 32'h0000BEEF, 1'b0);
    xact0(1'b0, 16'h0010, 2'b00, 1'b0, 32'd0, 32'hFFFFFFEF, 1'b0);
    xact0(1'b0, 16'h0011, 2'b00, 1'b1, 32'd0, 32'h000000BE, 1'b0);

    // Range boundary and errors.
    xact0(1'b1, 16'h0FFC, 2'b10, 1'b0, 32'h11223344, 32'd0, 1'b0);
    xact0(1'b0, 16'h0FFC, 2'b10, 1'b0, 32'd0, 32'h11223344, 1'b0);
    xact0(1'b0, 16'h1000, 2'b10, 1'b0, 32'd0, 32'd0, 1'b1);
    xact0(1'b1, 16'h1000, 2'b10, 1'b0, 32'h55555555, 32'd0, 1'b1);
    xact0(1'b1, 16'h0010, 2'b11, 1'b0, 32'hFFFFFFFF, 32'd0, 1'b1);
    xact0(1'b0, 16'h0010, 2'b10, 1'b0, 32'd0, 32'h80ADBEEF, 1'b0);
    xact0(1'b0, 16'h0FFC, 2'b10, 1'b0, 32'd0, 32'h11223344, 1'b0);

    // Misaligned accesses.
`ifdef DMEM_ALIGN_CHECK_EN
    xact0(1'b0, 16'h0011, 2'b10, 1'b0, 32'd0, 32'd0, 1'b1);
    xact0(1'b0, 16'h0013, 2'b01, 1'b1, 32'd0, 32'd0, 1'b1);
    xact0(1'b1, 16'h0011, 2'b10, 1'b0, 32'h0BADF00D, 32'd0, 1'b1);
`else
    xact0(1'b0, 16'h0011, 2'b10, 1'b0, 32'd0, 32'h80ADBEEF, 1'b0);
    xact0(1'b0, 16'h0013, 2'b01, 1'b1, 32'd0, 32'h000080AD, 1'b0);
    xact0(1'b1, 16'h0011, 2'b10, 1'b0, 32'h80ADBEEF, 32'd0, 1'b0);
`endif
    xact0(1'b0, 16'h0010, 2'b10, 1'b0, 32'd0, 32'h80ADBEEF, 1'b0);

    // Backpressure: response held with a competing request pending.
    bus0.rsp_ready = 1'b0;
    issue0(1'b0, 16'h0010, 2'b10, 1'b0, 32'd0, 1'b1, 32'h80ADBEEF, 1'b0);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus0.rsp_valid && n < 60);
    if (!bus0.rsp_valid) fail_timeout("backpressure rsp_valid");
    @(posedge clk); #1;
    bus0.req_valid = 1'b1; bus0.req_write = 1'b1; bus0.req_wdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp rsp_valid", {31'd0, bus0.rsp_valid}, 32'd1);
      chk("bp rsp_rdata", bus0.rsp_rdata, 32'h80ADBEEF);
      chk("bp req_ready", {31'd0, bus0.req_ready}, 32'd0);
    end
    @(posedge clk); #1;
    bus0.req_valid = 1'b0;
    bus0.rsp_ready = 1'b1;
    drain("backpressure drain");
    xact0(1'b0, 16'h0010, 2'b10, 1'b0, 32'd0, 32'h80ADBEEF, 1'b0);

    // Reset during WAIT abandons a store.
    xact0(1'b1, 16'h0020, 2'b10, 1'b0, 32'hCAFEF00D, 32'd0, 1'b0);
    issue0(1'b1, 16'h0020, 2'b10, 1'b0, 32'h12345678, 1'b0, 32'd0, 1'b0);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midreset req_ready", {31'd0, bus0.req_ready}, 32'd0);
    chk("midreset rsp_valid", {31'd0, bus0.rsp_valid}, 32'd0);
    chk("midreset rsp_rdata", bus0.rsp_rdata, 32'd0);
    @(posedge clk); #1 reset = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("after midreset rsp_valid", {31'd0, bus0.rsp_valid}, 32'd0);
    end
    chk("after midreset req_ready", {31'd0, bus0.req_ready}, 32'd1);
    @(posedge clk); #1;
    xact0(1'b0, 16'h0020, 2'b10, 1'b0, 32'd0, 32'hCAFEF00D, 1'b0);

    // Zero wait states: latency and back-to-back throughput.
    issue1(1'b1, 16'h0000, 32'hA5A55A5A, 32'd0, 1'b0);
    wait_rsp1(lat);
    chk("latency w0", lat, 32'd1);
    issue1(1'b0, 16'h0000, 32'd0, 32'hA5A55A5A, 1'b0);
    wait_rsp1(lat);
    for (int i = 0; i < 4; i++) q1.push_back('{rdata: 32'hA5A55A5A, err: 1'b0});
    bus1.req_valid = 1'b1; bus1.req_write = 1'b0; bus1.req_addr = 16'h0000;
    bus1.req_size = 2'b10;
    n = 0;
    while (acc_t.size() < 4 && n < 60) begin
      @(negedge clk); n++;
      if (bus1.req_valid && bus1.req_ready) acc_t.push_back(cyc);
    end
    @(posedge clk); #1 bus1.req_valid = 1'b0;
    if (acc_t.size() < 4) fail_timeout("w0 back-to-back accepts");
    else for (int i = 1; i < 4; i++) chk("w0 accept period", acc_t[i] - acc_t[i-1], 32'd2);
    drain("w0 drain");

    chk("dut_w2 scoreboard empty", q0.size(), 32'd0);
    chk("dut_w0 scoreboard empty", q1.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
